// File: rtl/spi_regfile_p.sv
// SPI peripheral register file: frames are R/W bit, address, then data, MSB first.
// All SPI pins are resynchronised into clk; writes commit on chip-select release.
module spi_regfile_p #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 5,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int F     = 1 + ADDR_W + DATA_W;
    localparam int CMD_N = 1 + ADDR_W;
    localparam int CW    = $clog2(F + 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    state_t              state_q;
    logic [2:0]          sclk_sync;
    logic [2:0]          ncs_sync;
    logic [1:0]          copi_sync;
    logic [CW-1:0]       bit_cnt;
    logic [ADDR_W:0]     cmd_q;
    logic [ADDR_W:0]     cmd_next;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   out_sh;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
    logic sample_edge, shift_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '0;
            copi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            ncs_sync  <= {ncs_sync[1:0], ncs};
            copi_sync <= {copi_sync[0], copi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign copi_s    = copi_sync[1];

    // sclk activity only matters while the chip is selected
    assign sample_edge = ~ncs_sync[1] & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = ~ncs_sync[1] & (SAMPLE_RISE ? sclk_fall : sclk_rise);

    assign cmd_next = {cmd_q[ADDR_W-1:0], copi_s};

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bit_cnt  <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            out_sh   <= '0;
            cipo_oe  <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (ncs_fall) begin
                state_q <= CMD;
                bit_cnt <= '0;
                cmd_q   <= '0;
                data_q  <= '0;
                out_sh  <= '0;
                cipo_oe <= 1'b0;
            end else if (ncs_rise) begin
                state_q <= IDLE;
                out_sh  <= '0;
                cipo_oe <= 1'b0;
                // out-of-range addresses match no register and are dropped
                if (state_q == HOLD && cmd_q[ADDR_W]) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cmd_q[ADDR_W-1:0] == ADDR_W'(i)) begin
                            regs_q[i] <= data_q;
                            wr_pulse  <= 1'b1;
                            wr_addr   <= cmd_q[ADDR_W-1:0];
                        end
                    end
                end
            end else begin
                case (state_q)
                    CMD: begin
                        if (sample_edge) begin
                            cmd_q   <= cmd_next;
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(CMD_N - 1)) begin
                                state_q <= DATA;
                                if (!cmd_next[ADDR_W]) begin
                                    out_sh  <= rd_val;
                                    cipo_oe <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sample_edge) begin
                            data_q  <= (data_q << 1) | DATA_W'(copi_s);
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(F - 1)) state_q <= HOLD;
                        end else if (shift_edge && cipo_oe && bit_cnt > CW'(CMD_N)) begin
                            // no shift before the first data sample: MSB must be seen first
                            out_sh <= out_sh << 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cipo = cipo_oe & out_sh[DATA_W-1];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_regfile_p.sv
// Bench for spi_regfile_p: a mode-0 default instance and a mode-3 16-bit instance.
// Write commits are checked against an expected queue by per-instance monitors.
module tb_spi_regfile_p;

    localparam time HALF = 80ns;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         sclk_a = 1'b0, copi_a = 1'b0, ncs_a = 1'b1;
    logic         cipo_a, cipo_oe_a, wr_pulse_a;
    logic [39:0]  regs_flat_a;
    logic [6:0]   wr_addr_a;

    logic         sclk_b = 1'b1, copi_b = 1'b0, ncs_b = 1'b1;
    logic         cipo_b, cipo_oe_b, wr_pulse_b;
    logic [255:0] regs_flat_b;
    logic [3:0]   wr_addr_b;

    logic [14:0]  exp_q_a[$];
    logic [19:0]  exp_q_b[$];
    logic [39:0]  exp_regs_a = '0;
    logic [255:0] exp_regs_b = '0;

    int n_checks = 0;
    int n_pass   = 0;

    spi_regfile_p u_dut_a (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a),
        .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_flat(regs_flat_a),
        .wr_pulse(wr_pulse_a), .wr_addr(wr_addr_a)
    );

    spi_regfile_p #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .CPOL(1), .CPHA(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b),
        .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_flat(regs_flat_b),
        .wr_pulse(wr_pulse_b), .wr_addr(wr_addr_b)
    );

    // clock/reset
    always #5ns clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver tasks
    task automatic set_sclk(input int sel, input logic v);
        if (sel == 0) sclk_a = v; else sclk_b = v;
    endtask

    task automatic set_copi(input int sel, input logic v);
        if (sel == 0) copi_a = v; else copi_b = v;
    endtask

    task automatic set_ncs(input int sel, input logic v);
        if (sel == 0) ncs_a = v; else ncs_b = v;
    endtask

    task automatic sample_rx(input int sel, inout logic [31:0] rx, inout int oe_low);
        logic c, oe;
        c  = (sel == 0) ? cipo_a : cipo_b;
        oe = (sel == 0) ? cipo_oe_a : cipo_oe_b;
        rx = {rx[30:0], c};
        if (oe !== 1'b1) oe_low++;
    endtask

    task automatic spi_frame(input int sel, input int nbits, input logic [31:0] frame,
                             input int first_rx, input bit raise_ncs,
                             output logic [31:0] rx, output int oe_low);
        logic cpol, b;
        cpol   = (sel != 0);
        rx     = '0;
        oe_low = 0;
        set_ncs(sel, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            b = frame[nbits-1-i];
            if (sel == 0) begin
                set_copi(sel, b);
                #HALF;
                if (i >= first_rx) sample_rx(sel, rx, oe_low);
                set_sclk(sel, ~cpol);
                #HALF;
                set_sclk(sel, cpol);
            end else begin
                #HALF;
                set_sclk(sel, ~cpol);
                set_copi(sel, b);
                #HALF;
                if (i >= first_rx) sample_rx(sel, rx, oe_low);
                set_sclk(sel, cpol);
            end
        end
        #HALF;
        if (raise_ncs) set_ncs(sel, 1'b1);
        #(4 * HALF);
    endtask

    task automatic write_a(input logic [6:0] addr, input logic [7:0] data, input bit commits);
        logic [31:0] rx;
        int oe_low;
        if (commits) begin
            exp_q_a.push_back({addr, data});
            exp_regs_a[addr*8 +: 8] = data;
        end
        spi_frame(0, 16, {16'h0, 1'b1, addr, data}, 99, 1'b1, rx, oe_low);
    endtask

    task automatic read_a(input string name, input logic [6:0] addr, input logic [7:0] exp);
        logic [31:0] rx;
        int oe_low;
        spi_frame(0, 16, {16'h0, 1'b0, addr, 8'h00}, 8, 1'b1, rx, oe_low);
        check({name, "_data"}, rx[7:0], exp);
        check({name, "_oe_low_count"}, oe_low, 0);
        check({name, "_oe_after"}, {cipo_oe_a, cipo_a}, 2'b00);
    endtask

    // scoreboard monitors: each commit pops one expected {addr,data}
    initial forever begin
        @(negedge clk);
        if (wr_pulse_a === 1'b1) begin
            if (exp_q_a.size() == 0) begin
                n_checks++;
                $display("FAIL wr_a_unexpected: got pulse addr=%0d expected none", wr_addr_a);
            end else begin
                check("wr_commit_a", {wr_addr_a, regs_flat_a[wr_addr_a*8 +: 8]}, exp_q_a.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (wr_pulse_b === 1'b1) begin
            if (exp_q_b.size() == 0) begin
                n_checks++;
                $display("FAIL wr_b_unexpected: got pulse addr=%0d expected none", wr_addr_b);
            end else begin
                check("wr_commit_b", {wr_addr_b, regs_flat_b[wr_addr_b*16 +: 16]}, exp_q_b.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rx;
        int oe_low;

        #43ns;
        check("rst_regs_a", regs_flat_a, 40'h0);
        check("rst_outs_a", {cipo_a, cipo_oe_a, wr_pulse_a, wr_addr_a}, 10'h0);
        check("rst_regs_b_hi", regs_flat_b[255:192], 64'h0);
        rst_n = 1'b1;
        #(4 * HALF);

        write_a(7'h02, 8'hA5, 1'b1);
        check("regs_after_w2", regs_flat_a, exp_regs_a);
        read_a("read_r2", 7'h02, 8'hA5);
        check("regs_after_r2", regs_flat_a, exp_regs_a);

        write_a(7'h05, 8'hFF, 1'b0);
        check("regs_after_w5", regs_flat_a, exp_regs_a);
        read_a("read_r5", 7'h05, 8'h00);

        // 10 of 16 bits of a write to reg1, then a complete one
        spi_frame(0, 10, 32'h0000_813C >> 6, 99, 1'b1, rx, oe_low);
        check("regs_after_short", regs_flat_a, exp_regs_a);
        write_a(7'h01, 8'h3C, 1'b1);
        check("regs_after_w1", regs_flat_a, exp_regs_a);

        write_a(7'h00, 8'h5A, 1'b1);
        write_a(7'h04, 8'hC3, 1'b1);
        check("regs_after_w0_w4", regs_flat_a, exp_regs_a);
        read_a("read_r4", 7'h04, 8'hC3);
        read_a("read_r0", 7'h00, 8'h5A);

        // mode 3, 16-bit data: 21-bit frame plus three trailing bits that must be ignored
        exp_q_b.push_back({4'hF, 16'hBEEF});
        exp_regs_b[255:240] = 16'hBEEF;
        spi_frame(1, 24, 32'h00FD_F77D, 99, 1'b1, rx, oe_low);
        check("regs_b_15", regs_flat_b[255:240], 16'hBEEF);
        check("regs_b_rest", regs_flat_b[239:0] != '0, 1'b0);
        spi_frame(1, 21, 32'h000F_0000, 5, 1'b1, rx, oe_low);
        check("read_b_15", rx[15:0], 16'hBEEF);
        check("read_b_oe_low_count", oe_low, 0);

        // reset in the middle of a write to reg3 (12 of 16 bits sent)
        spi_frame(0, 12, 32'h0000_8377 >> 4, 99, 1'b0, rx, oe_low);
        rst_n = 1'b0;
        exp_regs_a = '0;
        exp_regs_b = '0;
        #50ns;
        check("midrst_regs_a", regs_flat_a, 40'h0);
        check("midrst_outs_a", {cipo_a, cipo_oe_a, wr_pulse_a, wr_addr_a}, 10'h0);
        check("midrst_regs_b_hi", regs_flat_b[255:192], 64'h0);
        rst_n = 1'b1;
        #(4 * HALF);
        ncs_a = 1'b1;
        #(4 * HALF);
        check("regs_after_rst_rise", regs_flat_a, exp_regs_a);
        check("wr_addr_after_rst_rise", wr_addr_a, 7'h00);
        write_a(7'h03, 8'h77, 1'b1);
        check("regs_after_w3", regs_flat_a, exp_regs_a);
        read_a("read_r3", 7'h03, 8'h77);

        #(4 * HALF);
        check("exp_q_a_drained", exp_q_a.size(), 0);
        check("exp_q_b_drained", exp_q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_regfile_p.md
SPI_REGFILE_P -- requirements
Module: spi_regfile_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/data width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width in bits (1..8).
REQ-003 SHALL have parameter NUM_REGS, default 5, implemented registers, 1..2**ADDR_W.
REQ-004 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-005 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL have port clk, input, 1, system clock; clock clk.
REQ-007 SHALL have port rst_n, input, 1, reset; rst_n is asynchronous, active-low.
REQ-008 SHALL have port sclk, input, 1, SPI clock, asynchronous to clk.
REQ-009 SHALL have port copi, input, 1, controller-out data.
REQ-010 SHALL have port ncs, input, 1, chip select, active-low.
REQ-011 SHALL have port cipo, output, 1, peripheral-out data.
REQ-012 SHALL have port cipo_oe, output, 1, output enable for cipo pad.
REQ-013 SHALL have port regs_flat, output, NUM_REGS*DATA_W, register contents; reg i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port wr_pulse, output, 1, one-clk strobe on each committed write.
REQ-015 SHALL have port wr_addr, output, ADDR_W, address of last committed write.

Function
REQ-016 SHALL pass sclk, copi and ncs each through a 2-flop synchronizer before use; edges detected from a 3rd sclk/ncs stage; clk frequency >= 8x sclk.
REQ-017 SHALL use frame format, MSB first: bit R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits; frame length F = 1+ADDR_W+DATA_W.
REQ-018 SHALL sample copi on the sample edge selected by CPOL/CPHA and shift cipo on the opposite edge.
REQ-019 SHALL implement FSM IDLE -> CMD (on ncs fall) -> DATA (after 1+ADDR_W samples) -> HOLD (after F samples) -> IDLE (on ncs rise).
REQ-020 SHALL return to IDLE from any state on ncs rise; bit counter and shift register cleared on every ncs fall.
REQ-021 SHALL ignore sample edges in HOLD; bits beyond F do not alter the captured frame.
REQ-022 SHALL commit a write only on ncs rise in HOLD with R/W = 1 and address < NUM_REGS; register updates one clk after the ncs-rise detection, with wr_pulse high in that same cycle and wr_addr updated.
REQ-023 SHALL discard short frames (ncs rise before HOLD) and writes to address >= NUM_REGS: no register change, no wr_pulse.
REQ-024 SHALL, for reads, on entering DATA load reg[addr] (0 if addr >= NUM_REGS) into the output shifter and present its MSB on cipo before the first DATA sample edge; for CPHA = 0, cipo changes on each following shift edge.
REQ-025 SHALL drive cipo_oe = 1 only in DATA and HOLD states of a read frame; cipo = 0 whenever cipo_oe = 0; cipo holds LSB in HOLD.
REQ-026 SHALL ensure that a read returns the register value as of the DATA-phase load; a write commit never occurs during a read frame.
REQ-027 SHALL ignore sclk edges while ncs is high.

Reset
REQ-028 SHALL, when rst_n is low, asynchronously clear all registers, regs_flat, wr_addr, wr_pulse, cipo, cipo_oe, counters and synchronizers, and force FSM to IDLE.
REQ-029 SHALL, after reset release with ncs held low mid-frame, perform no commit until a fresh ncs fall/rise pair has occurred.

Verification
REQ-030 SHALL cover: defaults, mode 0, write 0x80|0x02, data 0xA5, then ncs rise -> reg2 = 0xA5, wr_pulse for 1 clk, wr_addr = 2.
REQ-031 SHALL cover: read addr 0x02 after REQ-030 -> cipo shifts 1,0,1,0,0,1,0,1, cipo_oe high during data, regs unchanged.
REQ-032 SHALL cover: write addr 0x05 (>= NUM_REGS), data 0xFF -> no change, no wr_pulse; read addr 0x05 -> 0x00.
REQ-033 SHALL cover: write frame with 10 of 16 bits, then ncs rise -> discarded; a following full frame commits correctly.
REQ-034 SHALL cover: CPOL = 1, CPHA = 1, DATA_W = 16, ADDR_W = 4, NUM_REGS = 16, 24-bit frame writing 0xBEEF to reg 15 -> regs_flat[255:240] = 0xBEEF; read-back equal.
REQ-035 SHALL cover: rst_n asserted mid-write after 12 bits -> all outputs 0; no commit on the subsequent ncs rise.
